// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and defaults for the fetch sequencer and its neighbours
package cpu_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_CNT_W  = 16;

    // Opcode the decoder recognises as end-of-program; it raises halt on it.
    localparam logic [7:0] HALT_OPCODE = 8'h76;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        INIT = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with clear, enable and saturation at all-ones
// Ports: clk, reset (sync, active-high), clr (priority over en), en, count[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - launch/run controller for the instruction fetch unit
// Ports: clk, reset (sync, active-high); start/start_addr_in launch a program;
// halt/stall_req from decoder/datapath; ack acknowledges done. Outputs: init pulse,
// start_addr, fetch_unit_en, busy, done, cycle_count, prog_count.
// Optional macro FETCH_SEQUENCER_WATCHDOG_EN adds WDOG_LIMIT and a timeout output.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W  = DEFAULT_CNT_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
`ifdef FETCH_SEQUENCER_WATCHDOG_EN
    ,
    parameter int WDOG_LIMIT = 4095
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr_in,
    input  logic              halt,
    input  logic              stall_req,
    input  logic              ack,
    output logic              init,
    output logic [ADDR_W-1:0] start_addr,
    output logic              fetch_unit_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [1:0]        prog_count
`ifdef FETCH_SEQUENCER_WATCHDOG_EN
    ,
    output logic              timeout
`endif
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic         launch;
    logic         wdog_hit;

    assign launch = (state == IDLE) && start;

`ifdef FETCH_SEQUENCER_WATCHDOG_EN
    // Fires in the RUN cycle whose increment brings the count to the limit,
    // so DONE shows exactly WDOG_LIMIT counted cycles.
    assign wdog_hit = (state == RUN) && (cycle_count == CNT_W'(WDOG_LIMIT - 1));
`else
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = INIT;
            INIT: state_next = RUN;
            RUN:  if (halt || wdog_hit) state_next = DONE;
            DONE: if (ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // prog_count and start_addr update on the launch edge so the memory sees
    // the new program selector and entry address during the init pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            start_addr <= '0;
            prog_count <= 2'd0;
        end else begin
            state <= state_next;
            if (launch) begin
                start_addr <= start_addr_in;
                prog_count <= prog_count + 2'd1;
            end
        end
    end

`ifdef FETCH_SEQUENCER_WATCHDOG_EN
    // A halt on the limit cycle is a normal completion, so halt masks the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout <= 1'b0;
        end else if (launch) begin
            timeout <= 1'b0;
        end else if (wdog_hit && !halt) begin
            timeout <= 1'b1;
        end
    end
`endif

    // Cleared on the launch edge so INIT already reads zero; counts every RUN
    // cycle including stalled ones and the halting one, frozen in DONE.
    sat_counter #(
        .W(CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (launch),
        .en    (state == RUN),
        .count (cycle_count)
    );

    assign init          = (state == INIT);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign fetch_unit_en = (state == RUN) && !stall_req && !halt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam int CNT_W  = 16;
    localparam int ADDR_W = 8;
`ifdef FETCH_SEQUENCER_WATCHDOG_EN
    localparam int WDOG_LIMIT = 20;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_addr_in;
    logic              halt;
    logic              stall_req;
    logic              ack;
    logic              init;
    logic [ADDR_W-1:0] start_addr;
    logic              fetch_unit_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  cycle_count;
    logic [1:0]        prog_count;
`ifdef FETCH_SEQUENCER_WATCHDOG_EN
    logic              timeout;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(
        .CNT_W (CNT_W),
        .ADDR_W(ADDR_W)
`ifdef FETCH_SEQUENCER_WATCHDOG_EN
        ,
        .WDOG_LIMIT(WDOG_LIMIT)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_addr_in(start_addr_in),
        .halt         (halt),
        .stall_req    (stall_req),
        .ack          (ack),
        .init         (init),
        .start_addr   (start_addr),
        .fetch_unit_en(fetch_unit_en),
        .busy         (busy),
        .done         (done),
        .cycle_count  (cycle_count),
        .prog_count   (prog_count)
`ifdef FETCH_SEQUENCER_WATCHDOG_EN
        ,
        .timeout      (timeout)
`endif
    );

    typedef struct {
        logic [7:0] addr;
        logic [1:0] prog;
    } init_exp_t;

    typedef struct {
        int         cycles;
        logic [1:0] prog;
        logic [7:0] addr;
        logic       to;
    } done_exp_t;

    init_exp_t init_q[$];
    done_exp_t done_q[$];
    bit        fen_q[$];

    int         passed = 0;
    int         total  = 0;
    logic [1:0] exp_prog = 2'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic underflow(input string name);
        total++;
        $display("FAIL %s: DUT output with no expected entry (got 1 expected 0) at %0t", name, $time);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_init"}, 32'(init), 0);
        chk({tag, "_fetch_en"}, 32'(fetch_unit_en), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_cycle_count"}, 32'(cycle_count), 0);
        chk({tag, "_start_addr"}, 32'(start_addr), 0);
        chk({tag, "_prog_count"}, 32'(prog_count), 0);
`ifdef FETCH_SEQUENCER_WATCHDOG_EN
        chk({tag, "_timeout"}, 32'(timeout), 0);
`endif
    endtask

    // Monitor: samples on the falling edge, classifies the cycle from the
    // visible outputs and checks it against whatever the driver queued.
    logic             prev_init = 1'b0;
    logic             prev_done = 1'b0;
    logic [CNT_W-1:0] held_cnt  = '0;

    initial begin
        init_exp_t ie;
        done_exp_t de;
        bit        fe;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_init = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (init) begin
                    chk("init_one_cycle", 32'(prev_init), 0);
                    if (init_q.size() == 0) underflow("init_unexpected");
                    else begin
                        ie = init_q.pop_front();
                        chk("init_start_addr", 32'(start_addr), 32'(ie.addr));
                        chk("init_prog_count", 32'(prog_count), 32'(ie.prog));
                        chk("init_cycle_count", 32'(cycle_count), 0);
                        chk("init_fetch_en", 32'(fetch_unit_en), 0);
`ifdef FETCH_SEQUENCER_WATCHDOG_EN
                        chk("init_timeout", 32'(timeout), 0);
`endif
                    end
                end else if (done) begin
                    chk("done_fetch_en", 32'(fetch_unit_en), 0);
                    if (!prev_done) begin
                        if (done_q.size() == 0) underflow("done_unexpected");
                        else begin
                            de = done_q.pop_front();
                            chk("done_cycle_count", 32'(cycle_count), 32'(de.cycles));
                            chk("done_prog_count", 32'(prog_count), 32'(de.prog));
                            chk("done_start_addr", 32'(start_addr), 32'(de.addr));
                            chk("done_busy", 32'(busy), 1);
`ifdef FETCH_SEQUENCER_WATCHDOG_EN
                            chk("done_timeout", 32'(timeout), 32'(de.to));
`endif
                        end
                        held_cnt = cycle_count;
                    end else begin
                        chk("done_count_frozen", 32'(cycle_count), 32'(held_cnt));
                    end
                end else if (busy) begin
                    if (fen_q.size() == 0) underflow("run_unexpected");
                    else begin
                        fe = fen_q.pop_front();
                        chk("run_fetch_en", 32'(fetch_unit_en), 32'(fe));
                    end
                end else begin
                    chk("idle_fetch_en", 32'(fetch_unit_en), 0);
                end
                prev_init = init;
                prev_done = done;
            end
        end
    end

    // Driver for one program: launch, RUN for len cycles (halt on the last
    // unless nohalt), then ack after ack_delay DONE cycles. reset_at > 0 pulls
    // reset in that RUN cycle instead of finishing.
    task automatic run_prog(input logic [7:0] addr, input int len, input logic [31:0] stall_mask,
                            input bit hold_start, input int ack_delay, input int reset_at,
                            input bit nohalt);
        int guard = 0;
        bit s;
        bit h;
        while (busy && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("pre_launch_idle", 32'(busy), 0);
        start         = 1'b1;
        start_addr_in = addr;
        halt          = 1'($urandom);
        stall_req     = 1'($urandom);
        ack           = 1'($urandom);
        exp_prog      = exp_prog + 2'd1;
        init_q.push_back('{addr, exp_prog});
        @(posedge clk); #1;
        chk("init_after_start", 32'(init), 1);
        start         = hold_start;
        start_addr_in = 8'($urandom);
        halt          = 1'($urandom);
        stall_req     = 1'($urandom);
        ack           = 1'($urandom);
        for (int i = 1; i <= len; i++) begin
            @(posedge clk); #1;
            if (i == reset_at) begin
                reset     = 1'b1;
                start     = 1'b0;
                halt      = 1'b0;
                stall_req = 1'b0;
                ack       = 1'b0;
                @(posedge clk); #1;
                chk_all_zero("midrun_reset");
                reset    = 1'b0;
                exp_prog = 2'd0;
                return;
            end
            s = (i <= 32) ? stall_mask[i-1] : 1'($urandom);
            h = (i == len) && !nohalt;
            stall_req = s;
            halt      = h;
            start     = 1'($urandom);
            ack       = 1'($urandom);
            fen_q.push_back(!s && !h);
        end
        done_q.push_back('{len, exp_prog, addr, nohalt});
        @(posedge clk); #1;
        halt      = 1'($urandom);
        stall_req = 1'($urandom);
        start     = hold_start;
        ack       = 1'b0;
        for (int d = 0; d < ack_delay; d++) begin
            @(posedge clk); #1;
            halt      = 1'($urandom);
            stall_req = 1'($urandom);
        end
        ack = 1'b1;
        @(posedge clk); #1;
        ack       = 1'b0;
        start     = 1'b0;
        halt      = 1'b0;
        stall_req = 1'b0;
        chk("ack_idle_busy", 32'(busy), 0);
        chk("ack_idle_done", 32'(done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        start_addr_in = '0;
        halt          = 1'b0;
        stall_req     = 1'b0;
        ack           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        run_prog(8'h10, 5, 32'h0, 1'b0, 0, 0, 1'b0);
        run_prog(8'h20, 6, 32'h6, 1'b0, 1, 0, 1'b0);
        run_prog(8'h30, 4, 32'h0, 1'b1, 2, 0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            run_prog(8'($urandom), int'($urandom_range(1, 12)), $urandom, 1'($urandom),
                     int'($urandom_range(0, 3)), 0, 1'b0);
        end

        run_prog(8'h44, 8, 32'h0, 1'b0, 0, 4, 1'b0);
        run_prog(8'h45, 3, 32'h1, 1'b0, 0, 0, 1'b0);
        chk("relaunch_prog_count", 32'(prog_count), 1);

`ifdef FETCH_SEQUENCER_WATCHDOG_EN
        run_prog(8'h55, WDOG_LIMIT, 32'h0, 1'b0, 1, 0, 1'b1);
        chk("wdog_timeout_held", 32'(timeout), 1);
        run_prog(8'h66, 3, 32'h0, 1'b0, 0, 0, 1'b0);
        run_prog(8'h77, WDOG_LIMIT, 32'h0, 1'b0, 0, 0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("init_q_empty", 32'(init_q.size()), 0);
        chk("done_q_empty", 32'(done_q.size()), 0);
        chk("fen_q_empty", 32'(fen_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Launch and run controller for the instruction fetch unit.
- Accepts a "run program N from address A" request and issues a one-cycle init pulse to the instruction memory with the start address.
- Drives the fetch-enable while the program runs, gates fetch on stall requests from the datapath, and detects program completion via the decoder's halt flag.
- Reports busy/done and a cycle count to the testbench/host, with a done/ack handshake.

Parameters:
- CNT_W, 16, width of the executed-cycle counter.
- ADDR_W, 8, instruction address width.
- WDOG_LIMIT, 4095, cycle limit for the optional watchdog.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  launch request; sampled only in IDLE
- start_addr_in  in  ADDR_W  program entry address, captured with start
- halt  in  1  decoder flags the current instruction as halt
- stall_req  in  1  datapath requests fetch hold this cycle
- ack  in  1  host acknowledges done
- init  out  1  one-cycle pulse to the instruction memory
- start_addr  out  ADDR_W  registered entry address; stable from INIT until the next launch
- fetch_unit_en  out  1  advance PC this cycle
- busy  out  1  high in INIT, RUN and DONE
- done  out  1  high in DONE until ack
- cycle_count  out  CNT_W  cycles spent in RUN for the last or current program
- prog_count  out  2  launches since reset, mod 4; tracks the memory's program selector

Behaviour:
- States: IDLE, INIT, RUN, DONE; encoding is a 2-bit enum. Reset puts the FSM in IDLE.
- Reset values: init=0, fetch_unit_en=0, busy=0, done=0, cycle_count=0, start_addr=0, prog_count=0.
- IDLE:
  - start=1 captures start_addr_in and moves to INIT on the next edge.
  - start in any other state is ignored.
- INIT:
  - init=1 for exactly this one cycle; fetch_unit_en=0.
  - prog_count increments (wraps 3->0).
  - cycle_count clears to 0.
  - Unconditionally moves to RUN next cycle.
- RUN:
  - fetch_unit_en = !stall_req && !halt; this is a combinational decode of state and inputs, with no extra latency.
  - cycle_count increments every RUN cycle, including stalled ones, and saturates at all-ones.
  - halt=1 moves to DONE next edge. halt has priority over stall_req. The halting cycle is counted and does not advance the PC.
- DONE:
  - done=1, fetch_unit_en=0, and cycle_count is frozen.
  - ack=1 returns to IDLE next edge.
  - start asserted together with ack is ignored; the host must reassert start in IDLE.
- ack outside DONE has no effect. halt or stall_req outside RUN has no effect.
- reset mid-run: immediate return to IDLE with all outputs at reset values. prog_count also resets, so the host must relaunch from program 1.
- First launch after reset yields prog_count=1, matching the memory's first program slot.

Optional Feature:
- Macro: FETCH_SEQUENCER_WATCHDOG_EN.
- When defined:
  - In RUN, if cycle_count reaches WDOG_LIMIT without halt, the FSM goes to DONE and sets an extra output timeout=1.
  - timeout clears on the transition into INIT and on reset.
  - halt on the same cycle as the limit counts as a normal completion: timeout=0.
- When undefined: no timeout port, and RUN lasts until halt or reset.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_t enum (IDLE, INIT, RUN, DONE).
  - Default ADDR_W and CNT_W localparams.
  - Halt opcode constant, used by the decoder that drives halt.
- One natural sub-module: sat_counter (parameterised width, clear, enable, saturate), used for cycle_count.
- The FSM and output decode stay in fetch_sequencer.

Test Plan:
- Basic launch: reset 2 cycles, start=1 with start_addr_in=8'h10 -> init=1 exactly one cycle later, start_addr=8'h10, prog_count=1, then fetch_unit_en=1 each following cycle.
- Halt after 5 RUN cycles -> done=1 on the next cycle, cycle_count=5 frozen, fetch_unit_en=0; ack -> IDLE, busy=0.
- stall_req high for cycles 2-3 of RUN, halt at cycle 6 -> fetch_unit_en low exactly in those cycles and in the halt cycle; cycle_count=6.
- Three back-to-back programs with ack between -> prog_count 1, 2, 3; start held during DONE and on the ack cycle causes no launch.
- reset asserted mid-RUN at cycle 4 -> next cycle all outputs are 0 and the FSM is in IDLE; a relaunch gives prog_count=1.
- With FETCH_SEQUENCER_WATCHDOG_EN and WDOG_LIMIT=20, no halt -> DONE with timeout=1 and cycle_count=20. A second launch clears timeout during INIT.
